// File: rtl/exp_controller.sv
`default_nettype none
// ============================================================================
// Module      : exp_controller
// Description : Left-to-right square-and-multiply sequencer for modular
//               exponentiation (x^e mod m). Owns the Montgomery-domain
//               accumulator and base registers and drives a single external
//               Montgomery multiplier through a start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module exp_controller #(
    parameter int WIDTH = 512,
    parameter int EBITS = 512
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [EBITS-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    input  logic [WIDTH-1:0] Rmodm,
    input  logic [WIDTH-1:0] Rsquaredmodm,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             mm_start,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_m,
    input  logic             mm_done,
    input  logic [WIDTH-1:0] mm_result
);

    localparam int CW = (EBITS > 1) ? $clog2(EBITS) : 1;

    localparam logic [CW-1:0]    c_cnt_top = CW'(EBITS - 1);
    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TOMONT   = 3'd1,
        S_SKIP     = 3'd2,
        S_SQUARE   = 3'd3,
        S_MULT     = 3'd4,
        S_FROMMONT = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [EBITS-1:0] r_exp;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_xt;

    // Exponent bit currently being scanned.
    logic w_bit;
    // The multiplier answer is taken only after the launch cycle has passed,
    // so a done pulse coinciding with mm_start is never consumed.
    logic w_mm_ack;

    assign w_bit    = r_exp[r_cnt];
    assign w_mm_ack = !mm_start && mm_done;

    // Sequencer: state, counters, working registers and all registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_exp    <= '0;
            r_a      <= '0;
            r_xt     <= '0;
            done     <= 1'b0;
            result   <= '0;
            mm_start <= 1'b0;
            mm_a     <= '0;
            mm_b     <= '0;
            mm_m     <= '0;
        end else begin
            // mm_start is a single-cycle pulse unless a launch below re-arms it.
            mm_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_exp    <= exponent;
                        r_a      <= Rmodm;
                        r_cnt    <= c_cnt_top;
                        // mm_m holds the latched modulus for the whole run.
                        mm_m     <= modulus;
                        mm_a     <= x;
                        mm_b     <= Rsquaredmodm;
                        mm_start <= 1'b1;
                        r_state  <= S_TOMONT;
                    end
                end

                S_TOMONT: begin
                    if (w_mm_ack) begin
                        r_xt    <= mm_result;
                        r_state <= S_SKIP;
                    end
                end

                S_SKIP: begin
                    if (w_bit) begin
                        // First square operates on Rmodm (Montgomery one).
                        mm_a     <= r_a;
                        mm_b     <= r_a;
                        mm_start <= 1'b1;
                        r_state  <= S_SQUARE;
                    end else if (r_cnt == '0) begin
                        mm_a     <= r_a;
                        mm_b     <= c_one;
                        mm_start <= 1'b1;
                        r_state  <= S_FROMMONT;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_SQUARE: begin
                    if (w_mm_ack) begin
                        r_a      <= mm_result;
                        mm_a     <= mm_result;
                        mm_start <= 1'b1;
                        if (w_bit) begin
                            mm_b    <= r_xt;
                            r_state <= S_MULT;
                        end else if (r_cnt == '0) begin
                            mm_b    <= c_one;
                            r_state <= S_FROMMONT;
                        end else begin
                            mm_b    <= mm_result;
                            r_cnt   <= r_cnt - 1'b1;
                            r_state <= S_SQUARE;
                        end
                    end
                end

                S_MULT: begin
                    if (w_mm_ack) begin
                        r_a      <= mm_result;
                        mm_a     <= mm_result;
                        mm_start <= 1'b1;
                        if (r_cnt == '0) begin
                            mm_b    <= c_one;
                            r_state <= S_FROMMONT;
                        end else begin
                            mm_b    <= mm_result;
                            r_cnt   <= r_cnt - 1'b1;
                            r_state <= S_SQUARE;
                        end
                    end
                end

                S_FROMMONT: begin
                    if (w_mm_ack) begin
                        result  <= mm_result;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    // A new run needs start to drop first; result stays held.
                    if (!start) begin
                        done    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exp_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_exp_controller
// Description : Directed bench for exp_controller with a behavioural
//               Montgomery multiplier (m = 1009, R mod m = 15, R^-1 = 740).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exp_controller;

    localparam int W  = 512;
    localparam int EB = 512;

    localparam logic [W-1:0] c_m    = W'(1009);
    localparam logic [W-1:0] c_rm   = W'(15);
    localparam logic [W-1:0] c_r2   = W'(225);
    localparam logic [63:0]  c_rinv = 64'd740;
    localparam logic [W-1:0] c_junk = {16{32'hdeadbeef}};

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  x = '0;
    logic [EB-1:0] exponent = '0;
    logic [W-1:0]  modulus = '0;
    logic [W-1:0]  Rmodm = '0;
    logic [W-1:0]  Rsquaredmodm = '0;
    logic          done;
    logic [W-1:0]  result;
    logic          mm_start;
    logic [W-1:0]  mm_a;
    logic [W-1:0]  mm_b;
    logic [W-1:0]  mm_m;
    logic          mm_done = 1'b0;
    logic [W-1:0]  mm_result = '0;

    int n_vec = 0;
    int n_err = 0;

    // multiplier model state
    bit           busy = 1'b0;
    int           wcnt = 0;
    logic [W-1:0] la, lb, lres;
    int           op_cnt = 0;
    int           unstable = 0;
    int           overlap = 0;
    int           mbad = 0;
    bit           spur_en = 1'b0;
    bit           tog = 1'b0;
    int           lat_fixed = 3;
    bit           lat_rand = 1'b0;

    exp_controller #(.WIDTH(W), .EBITS(EB)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .x            (x),
        .exponent     (exponent),
        .modulus      (modulus),
        .Rmodm        (Rmodm),
        .Rsquaredmodm (Rsquaredmodm),
        .done         (done),
        .result       (result),
        .mm_start     (mm_start),
        .mm_a         (mm_a),
        .mm_b         (mm_b),
        .mm_m         (mm_m),
        .mm_done      (mm_done),
        .mm_result    (mm_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // a*b*R^-1 mod 1009
    function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] ar, br;
        logic [63:0]  p;
        ar = a % c_m;
        br = b % c_m;
        p  = (64'(ar[31:0]) * 64'(br[31:0])) % 64'd1009;
        p  = (p * c_rinv) % 64'd1009;
        return W'(p);
    endfunction

    // plain repeated multiplication: xv^n mod 1009
    function automatic logic [W-1:0] ref_pow(input logic [W-1:0] xv, input int n);
        logic [W-1:0] xr;
        logic [63:0]  r;
        xr = xv % c_m;
        r  = 64'd1;
        for (int i = 0; i < n; i++) r = (r * 64'(xr[31:0])) % 64'd1009;
        return W'(r);
    endfunction

    // Behavioural multiplier, evaluated on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            mm_done = 1'b0;
            tog     = ~tog;
            if (mm_start) begin
                if (busy) overlap++;
                if (mm_m !== c_m) mbad++;
                busy   = 1'b1;
                la     = mm_a;
                lb     = mm_b;
                lres   = mont(mm_a, mm_b);
                wcnt   = lat_rand ? int'($urandom_range(1, 20)) : lat_fixed;
                op_cnt++;
                if (spur_en) begin
                    mm_done   = 1'b1;
                    mm_result = c_junk;
                end
            end else if (busy) begin
                if (resetn && (mm_a !== la || mm_b !== lb || mm_m !== c_m)) unstable++;
                wcnt--;
                if (wcnt == 0) begin
                    mm_done   = 1'b1;
                    mm_result = lres;
                    busy      = 1'b0;
                end
            end else if (spur_en && tog) begin
                mm_done   = 1'b1;
                mm_result = c_junk;
            end
        end
    end

    task automatic run(input logic [W-1:0] xv, input logic [EB-1:0] ev, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        @(negedge clk);
        x = xv; exponent = ev; modulus = c_m; Rmodm = c_rm; Rsquaredmodm = c_r2;
        start = 1'b1;
        op_cnt = 0;
        for (int i = 0; i < 30000; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                x = '1; exponent = '1; modulus = W'(7); Rmodm = '0; Rsquaredmodm = '0;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", W'(seen), W'(1));
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_after_done", W'(done), W'(0));
    endtask

    initial begin
        int            cyc;
        logic [EB-1:0] ev;
        bit            hit;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", W'(done), W'(0));
        chk("rst_mm_start", W'(mm_start), W'(0));
        chk("rst_result", result, W'(0));
        chk("rst_mm_a", mm_a, W'(0));
        chk("rst_mm_b", mm_b, W'(0));
        chk("rst_mm_m", mm_m, W'(0));
        @(negedge clk);
        resetn = 1'b1;

        // spurious mm_done in IDLE
        spur_en = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        spur_en = 1'b0;
        chk("idle_spur_done", W'(done), W'(0));
        chk("idle_spur_mm_start", W'(mm_start), W'(0));

        // e = 0xaf, L = 3
        lat_fixed = 3; lat_rand = 1'b0;
        run(W'(2), EB'(8'haf), cyc);
        chk("af_result", result, ref_pow(W'(2), 175));
        chk("af_ops", W'(op_cnt), W'(16));
        release_start();

        // e = 0: two operations, result 1, latency 1+512+2*(L+1)
        run(W'(2), EB'(0), cyc);
        chk("e0_result", result, W'(1));
        chk("e0_ops", W'(op_cnt), W'(2));
        chk("e0_latency", W'(cyc), W'(521));
        release_start();

        // e = 1: x mod m
        run(W'(1500), EB'(1), cyc);
        chk("e1_result", result, W'(491));
        chk("e1_ops", W'(op_cnt), W'(4));
        release_start();

        // hand values: 2^10 = 1024 -> 15, 3^10 = 59049 -> 527
        run(W'(2), EB'(10), cyc);
        chk("2p10_result", result, W'(15));
        chk("2p10_ops", W'(op_cnt), W'(8));
        release_start();
        run(W'(3), EB'(10), cyc);
        chk("3p10_result", result, W'(527));
        release_start();

        // exponent MSB only: 2^(2^511) = 2^128 mod 1009; 2+512+1 operations
        lat_fixed = 1;
        ev = '0;
        ev[EB-1] = 1'b1;
        run(W'(2), ev, cyc);
        chk("msb_result", result, ref_pow(W'(2), 128));
        chk("msb_ops", W'(op_cnt), W'(515));
        release_start();

        // random latency with spurious pulses; start held high across DONE
        lat_rand = 1'b1; spur_en = 1'b1;
        unstable = 0; overlap = 0; mbad = 0;
        run(W'(2), EB'(8'haf), cyc);
        chk("rnd_result", result, ref_pow(W'(2), 175));
        chk("rnd_ops", W'(op_cnt), W'(16));
        repeat (12) @(posedge clk);
        #1;
        chk("hold_done", W'(done), W'(1));
        chk("hold_result", result, ref_pow(W'(2), 175));
        chk("hold_no_launch", W'(op_cnt), W'(16));
        release_start();
        run(W'(5), EB'(8'haf), cyc);
        chk("rnd2_result", result, ref_pow(W'(5), 175));
        release_start();
        spur_en = 1'b0;
        chk("operands_stable", W'(unstable), W'(0));
        chk("no_overlap", W'(overlap), W'(0));
        chk("mm_m_latched", W'(mbad), W'(0));

        // reset during the 5th wait
        lat_rand = 1'b0; lat_fixed = 3;
        @(negedge clk);
        x = W'(2); exponent = EB'(8'haf); modulus = c_m; Rmodm = c_rm; Rsquaredmodm = c_r2;
        start = 1'b1;
        op_cnt = 0;
        hit = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            #1;
            if (op_cnt == 5) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reach_5th_op", W'(hit), W'(1));
        @(posedge clk);
        #2;
        resetn = 1'b0;
        start  = 1'b0;
        #1;
        chk("arst_done", W'(done), W'(0));
        chk("arst_mm_start", W'(mm_start), W'(0));
        chk("arst_result", result, W'(0));
        chk("arst_mm_a", mm_a, W'(0));
        chk("arst_mm_b", mm_b, W'(0));
        chk("arst_mm_m", mm_m, W'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("late_done_ignored", W'(done), W'(0));
        chk("late_no_launch", W'(mm_start), W'(0));
        chk("late_result", result, W'(0));
        unstable = 0; overlap = 0; mbad = 0;
        run(W'(2), EB'(8'haf), cyc);
        chk("restart_result", result, ref_pow(W'(2), 175));
        chk("restart_ops", W'(op_cnt), W'(16));
        release_start();
        chk("restart_stable", W'(unstable + overlap + mbad), W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
